// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - mdu_op_e : E-stage MDU opcode encoding (codes 7 and above mean "no MDU op")
//   - default busy latencies for multiply and divide
//   - small decode helpers used by the scheduler and the arithmetic block
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    localparam int MDU_MULT_LAT_DEF = 5;
    localparam int MDU_DIV_LAT_DEF  = 10;

    // True for the four ops that occupy the unit for several cycles.
    function automatic logic mdu_is_arith(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic mdu_is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational arithmetic for the MDU.
//   i_op       : MDU opcode (selects signed/unsigned and mult/div)
//   i_rs, i_rt : operands (rs is the dividend / multiplicand)
//   o_res_hi   : product[63:32] for mult, remainder for div
//   o_res_lo   : product[31:0] for mult, quotient for div
//   o_div_zero : divisor is zero (only meaningful for div ops)
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    output logic [31:0] o_res_hi,
    output logic [31:0] o_res_lo,
    output logic        o_div_zero
);

    logic        w_signed;
    logic [63:0] w_a;
    logic [63:0] w_b;
    logic [63:0] w_prod;
    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_abs_rs;
    logic [31:0] w_abs_rt;
    logic [31:0] w_divisor;
    logic [31:0] w_uquot;
    logic [31:0] w_urem;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_signed = (i_op == MDU_MULT) || (i_op == MDU_DIV);

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are
    // then correct for both signed and unsigned operands.
    assign w_a    = {{32{w_signed & i_rs[31]}}, i_rs};
    assign w_b    = {{32{w_signed & i_rt[31]}}, i_rt};
    assign w_prod = w_a * w_b;

    // Signed divide via magnitudes. 0x80000000 has magnitude 2^31, which fits
    // unsigned, so MIN/-1 naturally yields quotient 0x80000000, remainder 0.
    assign w_rs_neg  = w_signed & i_rs[31];
    assign w_rt_neg  = w_signed & i_rt[31];
    assign w_abs_rs  = w_rs_neg ? (32'd0 - i_rs) : i_rs;
    assign w_abs_rt  = w_rt_neg ? (32'd0 - i_rt) : i_rt;

    assign o_div_zero = (i_rt == 32'd0);
    // Keep the divider well defined on /0; the result is discarded anyway.
    assign w_divisor  = o_div_zero ? 32'd1 : w_abs_rt;
    assign w_uquot    = w_abs_rs / w_divisor;
    assign w_urem     = w_abs_rs % w_divisor;

    // Truncation toward zero: remainder takes the dividend's sign.
    assign w_quot = (w_rs_neg ^ w_rt_neg) ? (32'd0 - w_uquot) : w_uquot;
    assign w_rem  = w_rs_neg ? (32'd0 - w_urem) : w_urem;

    assign o_res_hi = mdu_is_div(i_op) ? w_rem  : w_prod[63:32];
    assign o_res_lo = mdu_is_div(i_op) ? w_quot : w_prod[31:0];

endmodule

// File: rtl/mdu_sched.sv
// mdu_sched: multi-cycle multiply/divide controller owning HI/LO.
//   clk, reset : clock, synchronous active-high reset
//   e_op       : E-stage MDU opcode (mdu_pkg encoding)
//   e_rs, e_rt : E-stage forwarded operands
//   e_flush    : E-stage instruction cancelled, blocks issue/writes
//   d_md       : D-stage instruction is MDU-class
//   busy       : multi-cycle operation in flight
//   stall      : D-stage stall request (combinational)
//   hi, lo     : architectural HI/LO registers
// Results are computed at issue and parked in pending registers; HI/LO only
// change on the final busy edge, so readers never see partial values.
module mdu_sched
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = MDU_MULT_LAT_DEF,
    parameter int DIV_LAT  = MDU_DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  e_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        e_flush,
    input  logic        d_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic             r_pend_dz;
    logic [31:0]      w_pend_hi_next;
    logic [31:0]      w_pend_lo_next;
    logic             w_pend_dz_next;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      w_hi_next;
    logic [31:0]      w_lo_next;

    logic             w_busy;
    logic             w_is_arith;
    logic             w_issue;
    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;
    logic             w_div_zero;

    mdu_arith u_arith (
        .i_op       (e_op),
        .i_rs       (e_rs),
        .i_rt       (e_rt),
        .o_res_hi   (w_res_hi),
        .o_res_lo   (w_res_lo),
        .o_div_zero (w_div_zero)
    );

    assign w_busy     = (r_cnt != '0);
    assign w_is_arith = mdu_is_arith(e_op);
    assign w_issue    = w_is_arith && !e_flush && !w_busy;

    always_comb begin
        w_cnt_next     = r_cnt;
        w_pend_hi_next = r_pend_hi;
        w_pend_lo_next = r_pend_lo;
        w_pend_dz_next = r_pend_dz;
        w_hi_next      = r_hi;
        w_lo_next      = r_lo;

        if (w_busy) begin
            // Anything presented in E while busy is ignored.
            w_cnt_next = r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1) && !r_pend_dz) begin
                w_hi_next = r_pend_hi;
                w_lo_next = r_pend_lo;
            end
        end else if (w_issue) begin
            w_cnt_next     = mdu_is_div(e_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            w_pend_hi_next = w_res_hi;
            w_pend_lo_next = w_res_lo;
            // Divide by zero still runs the full latency but commits nothing.
            w_pend_dz_next = mdu_is_div(e_op) && w_div_zero;
        end else if (!e_flush) begin
            if (e_op == MDU_MTHI) begin
                w_hi_next = e_rs;
            end else if (e_op == MDU_MTLO) begin
                w_lo_next = e_rs;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_dz <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_pend_hi <= w_pend_hi_next;
            r_pend_lo <= w_pend_lo_next;
            r_pend_dz <= w_pend_dz_next;
            r_hi      <= w_hi_next;
            r_lo      <= w_lo_next;
        end
    end

    // Stall the D-stage MDU instruction while an op is issuing (even if it is
    // being flushed, which is conservative) and for every busy cycle.
    assign stall = d_md && (w_busy || w_is_arith);
    assign busy  = w_busy;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_mdu_sched.sv
module tb_mdu_sched;
    import mdu_pkg::*;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  e_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        e_flush;
    logic        d_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    mdu_sched #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk     (clk),
        .reset   (reset),
        .e_op    (e_op),
        .e_rs    (e_rs),
        .e_rt    (e_rt),
        .e_flush (e_flush),
        .d_md    (d_md),
        .busy    (busy),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        dmd;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    vec_t        vecs[9];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // The stall keeps MDU instructions in D while busy, so E never presents
    // one during a busy cycle in a legal pipeline.
    always @(negedge clk) begin
        if (!reset && busy && e_op inside {[3'd1:3'd6]}) begin
            errors++;
            $display("FAIL e_op_while_busy: got op %0d with busy=1 required none", e_op);
        end
    end

    // Issue one arithmetic op, follow it through its busy window and compare
    // the committed HI/LO against the scoreboard entry pushed at issue.
    task automatic run_arith(input string name, input logic [2:0] op, input logic [31:0] rs,
                             input logic [31:0] rt, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo, input logic dmd);
        int   lat;
        int   nbusy;
        exp_t e;
        lat = (op == MDU_DIV || op == MDU_DIVU) ? DIV_LAT : MULT_LAT;
        e_op = op; e_rs = rs; e_rt = rt; e_flush = 1'b0; d_md = dmd;
        e.hi = exp_hi; e.lo = exp_lo;
        sb.push_back(e);
        @(negedge clk);
        chk({name, " issue_stall"}, 32'(stall), 32'(dmd));
        chk({name, " issue_busy"}, 32'(busy), 32'd0);
        step();
        e_op = MDU_NONE; e_rs = '0; e_rt = '0;
        nbusy = 0;
        for (int c = 0; c < lat + 4; c++) begin
            @(negedge clk);
            if (!busy) break;
            nbusy++;
            chk({name, " busy_stall"}, 32'(stall), 32'(dmd));
            chk({name, " busy_hi_hold"}, hi, m_hi);
            chk({name, " busy_lo_hold"}, lo, m_lo);
            step();
        end
        chk({name, " busy_cycles"}, 32'(nbusy), 32'(lat));
        chk({name, " post_stall"}, 32'(stall), 32'd0);
        e = sb.pop_front();
        chk({name, " hi"}, hi, e.hi);
        chk({name, " lo"}, lo, e.lo);
        m_hi = e.hi;
        m_lo = e.lo;
        $display("txn %s op=%0d rs=%h rt=%h busy=%0d hi=%h lo=%h", name, op, rs, rt, nbusy, hi, lo);
        d_md = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; e_op = MDU_NONE; e_rs = '0; e_rt = '0; e_flush = 1'b0; d_md = 1'b0;
        m_hi = '0; m_lo = '0;
        step();
        step();
        @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        $display("txn reset busy=%0d hi=%h lo=%h", busy, hi, lo);
        step();
        reset = 1'b0;

        vecs[0] = '{MDU_MULT,  32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1};
        vecs[1] = '{MDU_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b1};
        vecs[2] = '{MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1};
        vecs[3] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b1};
        vecs[4] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1};
        vecs[5] = '{MDU_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b1};
        vecs[6] = '{MDU_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b1};
        vecs[7] = '{MDU_DIVU,  32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999, 1'b1};
        vecs[8] = '{MDU_MULT,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};

        for (int i = 0; i < 9; i++) begin
            run_arith($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                      vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].dmd);
        end

        // MTHI: single-cycle write, never busy
        e_op = MDU_MTHI; e_rs = 32'h1234_5678;
        @(negedge clk);
        chk("mthi issue_busy", 32'(busy), 32'd0);
        step();
        e_op = MDU_NONE; e_rs = '0;
        @(negedge clk);
        chk("mthi hi", hi, 32'h1234_5678);
        chk("mthi lo", lo, m_lo);
        chk("mthi busy", 32'(busy), 32'd0);
        m_hi = 32'h1234_5678;
        $display("txn mthi hi=%h lo=%h", hi, lo);
        step();

        // Flushed MULTU: stall follows the formula, nothing else happens
        e_op = MDU_MULTU; e_rs = 32'd5; e_rt = 32'd7; e_flush = 1'b1; d_md = 1'b1;
        @(negedge clk);
        chk("flush stall", 32'(stall), 32'd1);
        chk("flush issue_busy", 32'(busy), 32'd0);
        step();
        e_op = MDU_NONE; e_flush = 1'b0; d_md = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("flush busy", 32'(busy), 32'd0);
            chk("flush hi", hi, m_hi);
            chk("flush lo", lo, m_lo);
            step();
        end
        $display("txn flushed_multu busy=%0d hi=%h lo=%h", busy, hi, lo);

        // MTLO 0xAA, then DIVU by zero leaves HI/LO untouched
        e_op = MDU_MTLO; e_rs = 32'h0000_00AA;
        step();
        e_op = MDU_NONE; e_rs = '0;
        @(negedge clk);
        chk("mtlo lo", lo, 32'h0000_00AA);
        m_lo = 32'h0000_00AA;
        $display("txn mtlo hi=%h lo=%h", hi, lo);
        step();
        run_arith("divu_by_zero", MDU_DIVU, 32'h0000_1234, 32'd0, m_hi, m_lo, 1'b1);

        // Reset in busy cycle 4 of a DIV: cleared state, no late commit
        e_op = MDU_DIV; e_rs = 32'd100; e_rt = 32'd7;
        step();
        e_op = MDU_NONE; e_rs = '0; e_rt = '0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("rst_div busy_pre", 32'(busy), 32'd1);
            step();
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rst_div busy_c4", 32'(busy), 32'd1);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_div busy", 32'(busy), 32'd0);
        chk("rst_div hi", hi, 32'd0);
        chk("rst_div lo", lo, 32'd0);
        m_hi = '0; m_lo = '0;
        for (int k = 0; k < 12; k++) begin
            step();
            @(negedge clk);
            chk("rst_div no_commit_busy", 32'(busy), 32'd0);
            chk("rst_div no_commit_hi", hi, 32'd0);
            chk("rst_div no_commit_lo", lo, 32'd0);
        end
        $display("txn reset_during_div busy=%0d hi=%h lo=%h", busy, hi, lo);
        step();

        // Reset concurrent with issue: reset wins
        e_op = MDU_MULT; e_rs = 32'd3; e_rt = 32'd4; reset = 1'b1;
        step();
        reset = 1'b0; e_op = MDU_NONE; e_rs = '0; e_rt = '0;
        for (int k = 0; k < MULT_LAT + 2; k++) begin
            @(negedge clk);
            chk("rst_issue busy", 32'(busy), 32'd0);
            chk("rst_issue hi", hi, 32'd0);
            chk("rst_issue lo", lo, 32'd0);
            step();
        end
        $display("txn reset_with_issue busy=%0d hi=%h lo=%h", busy, hi, lo);

        run_arith("post_reset_mult", MDU_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mdu_sched.md
Name: mdu_sched

Overview:
- Multi-cycle multiply/divide controller for the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo issued from the E stage and sequences a fixed-latency operation.
- Owns the HI/LO registers.
- Raises a D-stage stall request while any MDU-class instruction in D would collide with an in-flight or just-issued operation.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu (>=1)
- DIV_LAT, 10, busy cycles for div/divu (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- e_op  in  3  E-stage MDU opcode (package encoding)
- e_rs  in  32  E-stage forwarded rs value
- e_rt  in  32  E-stage forwarded rt value
- e_flush  in  1  E-stage instruction is cancelled (exception/interrupt); suppresses issue this cycle
- d_md  in  1  D-stage instruction is MDU-class (mult/multu/div/divu/mfhi/mflo/mthi/mtlo)
- busy  out  1  operation in flight
- stall  out  1  D-stage stall request (combinational)
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset: busy=0, hi=0, lo=0, counter=0, pending results cleared. Any in-flight operation is discarded.
- issue = (e_op in {MULT,MULTU,DIV,DIVU}) && !e_flush && !busy.
- Issue at edge N:
  - Latch pending {hi,lo}:
    - MULT: signed 64-bit product e_rs*e_rt.
    - MULTU: unsigned 64-bit product.
    - DIV: lo=signed quotient, hi=signed remainder (sign of dividend, truncation toward zero).
    - DIVU: unsigned quotient/remainder.
  - Counter loads MULT_LAT or DIV_LAT.
- busy = (counter != 0). Busy is high for exactly LAT cycles (N+1 .. N+LAT).
- Each edge with counter != 0: counter decrements. On the edge where counter==1, pending is committed to hi/lo and busy falls. New hi/lo are visible in cycle N+LAT+1.
- hi/lo hold their value throughout busy; they never show partial results.
- MTHI/MTLO, when !e_flush && !busy: write e_rs into hi/lo at the next edge. No busy, single cycle.
- MTHI/MTLO while busy: ignored. This is unreachable because the stall holds them in D; the bench asserts it never occurs.
- Any MDU op in E while busy: ignored, no state change. Same assertion applies.
- Division by zero (DIV/DIVU with e_rt==0):
  - Issues normally and busy runs DIV_LAT cycles.
  - Commit leaves hi/lo unchanged.
- Signed overflow case DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- stall = d_md && (busy || e_op in {MULT,MULTU,DIV,DIVU}).
  - Covers the cycle of issue and every busy cycle.
  - Deasserts in cycle N+LAT+1, when the D instruction proceeds and mfhi/mflo read committed values.
- e_flush on the issue cycle: no issue, busy stays 0, hi/lo unchanged. stall still follows the formula above (conservative, harmless).
- reset concurrent with issue: reset wins.
- Edge case when LAT=1: busy is high one cycle and commit happens at the following edge.

Decomposition:
- Package mdu_pkg holds:
  - MDU_NONE=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6 (values 7 and above are treated as NONE).
  - Default latency constants.
- One natural sub-module, mdu_arith: combinational 64-bit product and quotient/remainder plus a divide-by-zero flag. The FSM/counter, pending registers, HI/LO and stall stay in mdu_sched.
- The E-stage decoder drives e_op; the D-stage decoder drives d_md.

Test Plan:
- MULT, rs=3, rt=0xFFFFFFFE -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; hi/lo stay 0 during busy.
- DIVU, rs=7, rt=2 -> busy high 10 cycles; then lo=3, hi=1.
- DIV, rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV, rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT issued with d_md=1 held throughout -> stall=1 on the issue cycle and all 5 busy cycles, 0 on the next cycle.
- MTHI, rs=0x12345678 -> hi=0x12345678 one edge later, busy never asserts.
- MULTU with e_flush=1 -> no busy, hi/lo unchanged.
- DIVU with rt=0, preceded by MTLO 0xAA -> busy for 10 cycles, lo stays 0xAA.
- DIV issued, then reset asserted at busy cycle 4 -> next cycle busy=0, hi=lo=0, and no late commit occurs.
